// File: rtl/prbs7_ber_ctrl.sv
// prbs7_ber_ctrl
//   Run controller for a PRBS7 bit-error-rate measurement. After start it
//   discards FLUSH_CYC cycles while the checker pipeline drains. It then waits
//   for LOCK_LEN consecutive error-free words, giving up after LOCK_TMO words.
//   Once locked it accumulates error statistics over windowLen words, or until
//   stop when windowLen is 0.
//
// Ports
//   clk          : 40MHz clock, rising edge
//   rst          : synchronous active-high reset
//   start        : pulse, begins a run (honoured in IDLE/DONE only)
//   stop         : pulse, aborts a run to DONE
//   windowLen    : words to measure, 0 = run until stop
//   errorCounter : per-word bit-error count from the checker
//   busy         : high in FLUSH, LOCK, COUNT
//   locked       : high in COUNT, held into DONE if COUNT was reached
//   done         : one-cycle pulse on entry to DONE
//   lockFail     : sticky, lock timed out
//   errorTotal   : saturating sum of errorCounter over COUNT words
//   wordTotal    : saturating count of COUNT words
//   errWords     : saturating count of COUNT words with errors
module prbs7_ber_ctrl #(
  parameter int FLUSH_CYC = 8,   // must be >= 1
  parameter int LOCK_LEN  = 16,
  parameter int LOCK_TMO  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] windowLen,
  input  logic [6:0]  errorCounter,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic        lockFail,
  output logic [47:0] errorTotal,
  output logic [47:0] wordTotal,
  output logic [31:0] errWords
);

  typedef enum logic [2:0] {IDLE, FLUSH, LOCK, COUNT, DONE} state_t;

  state_t      state;
  logic [31:0] flush_cnt, run_cnt, tmo_cnt;
  logic [47:0] err_tot, word_tot;
  logic [31:0] err_words;

  assign errorTotal = err_tot;
  assign wordTotal  = word_tot;
  assign errWords   = err_words;

  // Next values of the lock counters and saturating accumulators
  logic [31:0] run_nxt, tmo_nxt;
  logic [48:0] et_sum;
  logic [47:0] et_sat, wt_sat;
  logic [31:0] ew_sat;
  logic        win_hit;

  always_comb begin
    run_nxt = (errorCounter == 7'd0) ? run_cnt + 32'd1 : 32'd0;
    tmo_nxt = tmo_cnt + 32'd1;
    et_sum  = {1'b0, err_tot} + {42'd0, errorCounter};
    et_sat  = et_sum[48] ? '1 : et_sum[47:0];
    wt_sat  = (&word_tot)  ? word_tot  : word_tot + 48'd1;
    ew_sat  = (errorCounter == 7'd0 || (&err_words)) ? err_words
                                                      : err_words + 32'd1;
    // The word being counted this cycle is included in the window
    win_hit = (windowLen != 32'd0) && (wt_sat == {16'd0, windowLen});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      locked    <= 1'b0;
      done      <= 1'b0;
      lockFail  <= 1'b0;
      err_tot   <= '0;
      word_tot  <= '0;
      err_words <= '0;
      flush_cnt <= '0;
      run_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // start beats a simultaneous stop here
          if (start) begin
            state     <= FLUSH;
            busy      <= 1'b1;
            locked    <= 1'b0;
            lockFail  <= 1'b0;
            err_tot   <= '0;
            word_tot  <= '0;
            err_words <= '0;
            flush_cnt <= '0;
            run_cnt   <= '0;
            tmo_cnt   <= '0;
          end
        end
        FLUSH: begin
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (flush_cnt == FLUSH_CYC - 1) begin
            state <= LOCK;
          end else begin
            flush_cnt <= flush_cnt + 32'd1;
          end
        end
        LOCK: begin
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (run_nxt == LOCK_LEN) begin
            // lock is checked before timeout so it wins a tie
            state   <= COUNT;
            locked  <= 1'b1;
            run_cnt <= run_nxt;
          end else if (tmo_nxt == LOCK_TMO) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            lockFail <= 1'b1;
          end else begin
            run_cnt <= run_nxt;
            tmo_cnt <= tmo_nxt;
          end
        end
        COUNT: begin
          err_tot   <= et_sat;
          word_tot  <= wt_sat;
          err_words <= ew_sat;
          // stop and window completion together still give one DONE entry
          if (stop || win_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs7_ber_ctrl.sv
module tb_prbs7_ber_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [31:0] windowLen;
  logic [6:0]  errorCounter;
  logic        busy, locked, done, lockFail;
  logic [47:0] errorTotal, wordTotal;
  logic [31:0] errWords;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] MAX48 = 48'hFFFF_FFFF_FFFF;

  prbs7_ber_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .windowLen(windowLen), .errorCounter(errorCounter),
    .busy(busy), .locked(locked), .done(done), .lockFail(lockFail),
    .errorTotal(errorTotal), .wordTotal(wordTotal), .errWords(errWords)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start pulse, 8 FLUSH cycles, 16 zero-error LOCK words, then in COUNT
  task automatic start_run(input logic [31:0] wl, input string tag);
    windowLen    = wl;
    errorCounter = 7'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    repeat (23) tick();
    chk({tag, "_not_locked_yet"}, 64'(locked), 64'd0);
    tick();
    chk({tag, "_locked"}, 64'(locked), 64'd1);
    chk({tag, "_wt_zero_at_lock"}, 64'(wordTotal), 64'd0);
  endtask

  int npulse;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    windowLen = 32'd0; errorCounter = 7'd0;
    #1;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lockfail", 64'(lockFail), 64'd0);
    chk("rst_et", 64'(errorTotal), 64'd0);
    chk("rst_wt", 64'(wordTotal), 64'd0);
    chk("rst_ew", 64'(errWords), 64'd0);
    rst = 1'b0;
    tick();

    // clean 100-word window
    start_run(32'd100, "t1");
    repeat (99) tick();
    chk("t1_no_done_early", 64'(done), 64'd0);
    chk("t1_wt99", 64'(wordTotal), 64'd99);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_wt", 64'(wordTotal), 64'd100);
    chk("t1_et", 64'(errorTotal), 64'd0);
    chk("t1_locked", 64'(locked), 64'd1);
    chk("t1_busy_off", 64'(busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_wt_hold", 64'(wordTotal), 64'd100);
    chk("t1_locked_hold", 64'(locked), 64'd1);

    // 10-word window, errors on words 2 and 5, ignored start on word 7
    start_run(32'd10, "t2");
    for (int i = 1; i <= 10; i++) begin
      errorCounter = (i == 2 || i == 5) ? 7'd3 : 7'd0;
      start = (i == 7);
      tick();
    end
    start = 1'b0; errorCounter = 7'd0;
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_et", 64'(errorTotal), 64'd6);
    chk("t2_ew", 64'(errWords), 64'd2);
    chk("t2_wt", 64'(wordTotal), 64'd10);

    // lock never reached: every 10th LOCK word has an error
    windowLen = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_lockfail_cleared", 64'(lockFail), 64'd0);
    chk("t3_locked_cleared", 64'(locked), 64'd0);
    repeat (8) tick();
    for (int k = 1; k <= 1024; k++) begin
      errorCounter = (k % 10 == 0) ? 7'd1 : 7'd0;
      tick();
      if (k == 1023) begin
        chk("t3_busy_1023", 64'(busy), 64'd1);
        chk("t3_no_done_1023", 64'(done), 64'd0);
      end
    end
    errorCounter = 7'd0;
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_lockfail", 64'(lockFail), 64'd1);
    chk("t3_locked", 64'(locked), 64'd0);
    chk("t3_wt", 64'(wordTotal), 64'd0);
    chk("t3_et", 64'(errorTotal), 64'd0);
    tick();
    chk("t3_lockfail_sticky", 64'(lockFail), 64'd1);

    // open window, stop after 50 words; stop word counted
    start_run(32'd0, "t4");
    repeat (50) tick();
    chk("t4_wt50", 64'(wordTotal), 64'd50);
    chk("t4_busy", 64'(busy), 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_wt", 64'(wordTotal), 64'd51);
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("t4_single_pulse", 64'(npulse), 64'd0);

    // stop on the last window word, oversize errorCounter accumulated as-is
    start_run(32'd3, "t5");
    errorCounter = 7'd100; tick();
    errorCounter = 7'd0;   tick();
    errorCounter = 7'd5; stop = 1'b1; tick();
    errorCounter = 7'd0; stop = 1'b0;
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_et", 64'(errorTotal), 64'd105);
    chk("t5_ew", 64'(errWords), 64'd2);
    chk("t5_wt", 64'(wordTotal), 64'd3);
    tick();
    chk("t5_done_once", 64'(done), 64'd0);

    // errorTotal near full scale
    start_run(32'd0, "t6");
    force dut.err_tot = MAX48 - 48'd100;
    #1 release dut.err_tot;
    errorCounter = 7'd64; tick();
    chk("t6_add", 64'(errorTotal), 64'(MAX48 - 48'd36));
    force dut.err_tot = MAX48 - 48'd10;
    #1 release dut.err_tot;
    tick();
    chk("t6_sat", 64'(errorTotal), 64'(MAX48));
    tick();
    chk("t6_sat_hold", 64'(errorTotal), 64'(MAX48));
    errorCounter = 7'd0;
    stop = 1'b1; tick(); stop = 1'b0;

    // reset mid-COUNT, then a normal run started together with stop
    start_run(32'd0, "t7");
    repeat (5) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_locked", 64'(locked), 64'd0);
    chk("t7_rst_done", 64'(done), 64'd0);
    chk("t7_rst_wt", 64'(wordTotal), 64'd0);
    chk("t7_rst_et", 64'(errorTotal), 64'd0);
    tick();
    chk("t7_no_done_after_rst", 64'(done), 64'd0);
    chk("t7_idle", 64'(busy), 64'd0);
    stop = 1'b1;
    windowLen = 32'd5;
    start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t7_start_beats_stop", 64'(busy), 64'd1);
    repeat (24) tick();
    chk("t7_relocked", 64'(locked), 64'd1);
    repeat (5) tick();
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_wt", 64'(wordTotal), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
